// File: rtl/key_debounce.sv
// Push-button conditioner: two-stage synchroniser, per-key debounce counter and registered press/release pulses.
// Optional auto-repeat of key_press is built only when KEY_REPEAT_EN is defined.
module key_debounce #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_params
        $error("key_debounce: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] sample;
    logic [CW-1:0]     cnt_q [N_KEYS];
    logic [CW-1:0]     cnt_d [N_KEYS];
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [N_KEYS-1:0] rep_fire;

    // KEY is active low; the debounce logic works on the active-high sample.
    assign sample = ~sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= KEY;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        level_d = level_q;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sample[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Pulses are decoded from the next level so they align with the level edge.
    assign press_d   = (level_d & ~level_q) | rep_fire;
    assign release_d = ~level_d & level_q;

`ifdef KEY_REPEAT_EN
    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_PERIOD
    } rep_state_e;

    localparam int unsigned   RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned   RW          = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    rep_state_e    rep_q  [N_KEYS];
    rep_state_e    rep_d  [N_KEYS];
    logic [RW-1:0] rcnt_q [N_KEYS];
    logic [RW-1:0] rcnt_d [N_KEYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                rep_q[i]  <= REP_IDLE;
                rcnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                rep_q[i]  <= rep_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    // Gating on level_d keeps a repeat from landing on the release edge.
    always_comb begin
        rep_fire = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            rep_d[i]  = rep_q[i];
            rcnt_d[i] = '0;
            if (!level_d[i]) begin
                rep_d[i] = REP_IDLE;
            end else if (!level_q[i]) begin
                rep_d[i] = REP_DELAY;
            end else begin
                unique case (rep_q[i])
                    REP_DELAY: begin
                        if (rcnt_q[i] == DELAY_LAST) begin
                            rep_fire[i] = 1'b1;
                            rep_d[i]    = REP_PERIOD;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1);
                        end
                    end
                    REP_PERIOD: begin
                        if (rcnt_q[i] == PERIOD_LAST) begin
                            rep_fire[i] = 1'b1;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1);
                        end
                    end
                    default: begin
                        rep_d[i] = REP_DELAY;
                    end
                endcase
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule
